ice_pll_ctrl: RTL and testbench

PLL bring-up and supervision controller for the iCE40 `SB_PLL40_CORE` clock path of the TRNG. It runs in the reference-clock domain and drives the PLL's active-low reset. It waits for a qualified lock, then releases the downstream core reset. It retries on lock timeout, restarts on lock loss, and latches a fault after repeated failures, so the TRNG sampling logic never runs on an unlocked clock.

---
 rtl/ice_pll_ctrl_if.sv | 21 ++
 rtl/ice_pll_ctrl.sv | 135 +++++++++++++
 tb/tb_ice_pll_ctrl.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/ice_pll_ctrl_if.sv
// Signal bundle between the PLL supervision controller and the PLL / downstream core.
// master is the controller side; slave is the PLL and clock-consumer side.
interface ice_pll_ctrl_if;
  logic       PLL_LOCK;
  logic       PLL_RESETB;
  logic       CORE_RESET;
  logic       LOCKED;
  logic       FAULT;
  logic [3:0] RETRY_COUNT;
  logic [7:0] LOSS_COUNT;

  modport master (
    input  PLL_LOCK,
    output PLL_RESETB, CORE_RESET, LOCKED, FAULT, RETRY_COUNT, LOSS_COUNT
  );

  modport slave (
    output PLL_LOCK,
    input  PLL_RESETB, CORE_RESET, LOCKED, FAULT, RETRY_COUNT, LOSS_COUNT
  );
endinterface

// File: rtl/ice_pll_ctrl.sv
// PLL bring-up/supervision FSM: holds PLL reset, qualifies lock, releases the core reset,
// retries on lock timeout, restarts on lock loss and latches a fault after repeated failures.
module ice_pll_ctrl #(
  parameter int unsigned RESET_CYCLES  = 16,
  parameter int unsigned LOCK_TIMEOUT  = 4096,
  parameter int unsigned STABLE_CYCLES = 256,
  parameter int unsigned MAX_RETRIES   = 3
) (
  input  logic          REFERENCECLK,
  input  logic          RESET,
  ice_pll_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    S_HOLD,
    S_WAIT_LOCK,
    S_STABLE,
    S_RUN,
    S_FAULT
  } state_t;

  localparam logic [3:0] MAX_R = 4'(MAX_RETRIES);

  state_t      state, state_n;
  logic        sync_p0, lock_s;
  logic [31:0] hold_cnt, hold_n;
  logic [31:0] elapsed, elap_n;
  logic [31:0] stable_cnt, stab_n;
  logic [3:0]  retry, retry_n;
  logic [7:0]  loss, loss_n;
  logic        pll_resetb, core_reset, locked, fault;
  logic        run_go, timeout;

  // Qualification completes on the last required lock cycle; that beats a coincident timeout.
  always_comb begin
    run_go  = (state == S_STABLE) && lock_s && (stable_cnt == STABLE_CYCLES - 1);
    timeout = ((state == S_WAIT_LOCK) || (state == S_STABLE)) &&
              (elapsed == LOCK_TIMEOUT - 1) && !run_go;
  end

  always_comb begin
    state_n = state;
    hold_n  = hold_cnt;
    elap_n  = elapsed;
    stab_n  = stable_cnt;
    retry_n = retry;
    loss_n  = loss;
    case (state)
      S_HOLD: begin
        if (hold_cnt == RESET_CYCLES - 1) begin
          state_n = S_WAIT_LOCK;
          elap_n  = '0;
        end else begin
          hold_n = hold_cnt + 32'd1;
        end
      end
      S_WAIT_LOCK, S_STABLE: begin
        elap_n = elapsed + 32'd1;
        if (run_go) begin
          state_n = S_RUN;
          retry_n = '0;
        end else if (timeout) begin
          retry_n = retry + 4'd1;
          if (retry + 4'd1 == MAX_R) begin
            state_n = S_FAULT;
          end else begin
            state_n = S_HOLD;
            hold_n  = '0;
          end
        end else if (state == S_WAIT_LOCK) begin
          if (lock_s) begin
            state_n = S_STABLE;
            stab_n  = '0;
          end
        end else if (lock_s) begin
          stab_n = stable_cnt + 32'd1;
        end else begin
          // Elapsed time keeps running so a flapping lock still times out.
          state_n = S_WAIT_LOCK;
        end
      end
      S_RUN: begin
        if (!lock_s) begin
          state_n = S_HOLD;
          hold_n  = '0;
          if (loss != 8'hFF) loss_n = loss + 8'd1;
        end
      end
      S_FAULT: state_n = S_FAULT;
      default: begin
        state_n = S_HOLD;
        hold_n  = '0;
      end
    endcase
  end

  // Outputs are registered from the next state so they switch together with the state.
  always_ff @(posedge REFERENCECLK) begin
    if (RESET) begin
      state      <= S_HOLD;
      sync_p0    <= 1'b0;
      lock_s     <= 1'b0;
      hold_cnt   <= '0;
      elapsed    <= '0;
      stable_cnt <= '0;
      retry      <= '0;
      loss       <= '0;
      pll_resetb <= 1'b0;
      core_reset <= 1'b1;
      locked     <= 1'b0;
      fault      <= 1'b0;
    end else begin
      state      <= state_n;
      sync_p0    <= bus.PLL_LOCK;
      lock_s     <= sync_p0;
      hold_cnt   <= hold_n;
      elapsed    <= elap_n;
      stable_cnt <= stab_n;
      retry      <= retry_n;
      loss       <= loss_n;
      pll_resetb <= (state_n == S_WAIT_LOCK) || (state_n == S_STABLE) || (state_n == S_RUN);
      core_reset <= (state_n != S_RUN);
      locked     <= (state_n == S_RUN);
      fault      <= (state_n == S_FAULT);
    end
  end

  assign bus.PLL_RESETB  = pll_resetb;
  assign bus.CORE_RESET  = core_reset;
  assign bus.LOCKED      = locked;
  assign bus.FAULT       = fault;
  assign bus.RETRY_COUNT = retry;
  assign bus.LOSS_COUNT  = loss;

endmodule

// File: tb/tb_ice_pll_ctrl.sv
// Directed bench for ice_pll_ctrl: expected output snapshots are queued per cycle
// and compared when the run reaches that cycle.
module tb_ice_pll_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ice_pll_ctrl_if bus ();

  ice_pll_ctrl #(
    .RESET_CYCLES (4),
    .LOCK_TIMEOUT (64),
    .STABLE_CYCLES(8),
    .MAX_RETRIES  (2)
  ) dut (
    .REFERENCECLK(clk),
    .RESET       (rst),
    .bus         (bus)
  );

  typedef struct {
    int          cyc;
    string       tag;
    logic [15:0] val;
  } exp_t;

  exp_t q[$];
  int   cyc    = 0;
  int   n_chk  = 0;
  int   n_pass = 0;

  // {PLL_RESETB, CORE_RESET, LOCKED, FAULT, RETRY_COUNT, LOSS_COUNT}
  function automatic logic [15:0] mk(logic rb, logic cr, logic lk, logic ft,
                                     logic [3:0] rc, logic [7:0] lc);
    return {rb, cr, lk, ft, rc, lc};
  endfunction

  function automatic logic [15:0] obs();
    return {bus.PLL_RESETB, bus.CORE_RESET, bus.LOCKED, bus.FAULT,
            bus.RETRY_COUNT, bus.LOSS_COUNT};
  endfunction

  task automatic cmp(string tag, logic [15:0] o, logic [15:0] e);
    n_chk++;
    assert (o === e) n_pass++;
    else $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, o, e);
  endtask

  task automatic expect_at(int c, string tag, logic [15:0] v);
    exp_t e;
    e.cyc = c;
    e.tag = tag;
    e.val = v;
    q.push_back(e);
  endtask

  // Advance to the start of cycle t, comparing queued snapshots at each mid-cycle point.
  task automatic run_to(int t);
    while (cyc < t) begin
      @(negedge clk);
      while (q.size() > 0 && q[0].cyc <= cyc) begin
        if (q[0].cyc < cyc) cmp({q[0].tag, "_missed"}, 16'hxxxx, q[0].val);
        else                cmp(q[0].tag, obs(), q[0].val);
        void'(q.pop_front());
      end
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic do_reset(string tag);
    if (q.size() > 0) begin
      cmp({tag, "_leftover"}, 16'(q.size()), 16'd0);
      q.delete();
    end
    rst = 1'b1;
    bus.PLL_LOCK = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    cmp({tag, "_in_reset"}, obs(), mk(0, 1, 0, 0, 0, 0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc = 0;
  endtask

  localparam logic [15:0] HOLD0 = 16'h4000;  // reset values
  localparam logic [15:0] WAIT0 = 16'hC000;  // PLL released, core held
  localparam logic [15:0] RUN0  = 16'hA000;  // locked and running

  initial begin
    // Nominal bring-up followed by a lock loss in RUN.
    do_reset("nom");
    expect_at(0,  "nom_c0",    mk(0, 1, 0, 0, 0, 0));
    expect_at(3,  "nom_c3",    mk(0, 1, 0, 0, 0, 0));
    expect_at(4,  "nom_c4",    mk(1, 1, 0, 0, 0, 0));
    expect_at(20, "nom_c20",   mk(1, 1, 0, 0, 0, 0));
    expect_at(21, "nom_run",   mk(1, 0, 1, 0, 0, 0));
    expect_at(39, "loss_c39",  mk(1, 0, 1, 0, 0, 0));
    expect_at(42, "loss_c42",  mk(1, 0, 1, 0, 0, 0));
    expect_at(43, "loss_c43",  mk(0, 1, 0, 0, 0, 1));
    expect_at(46, "loss_c46",  mk(0, 1, 0, 0, 0, 1));
    expect_at(47, "loss_c47",  mk(1, 1, 0, 0, 0, 1));
    run_to(10);
    bus.PLL_LOCK = 1'b1;
    run_to(40);
    bus.PLL_LOCK = 1'b0;
    run_to(50);

    // One-cycle glitch while qualifying restarts the stable count.
    do_reset("glitch");
    expect_at(0,  "gl_c0",   HOLD0);
    expect_at(21, "gl_c21",  WAIT0);
    expect_at(26, "gl_c26",  WAIT0);
    expect_at(27, "gl_run",  RUN0);
    run_to(10);
    bus.PLL_LOCK = 1'b1;
    run_to(15);
    bus.PLL_LOCK = 1'b0;
    run_to(16);
    bus.PLL_LOCK = 1'b1;
    run_to(30);

    // No lock at all: two timeouts end in a sticky fault.
    do_reset("to");
    expect_at(0,   "to_c0",    HOLD0);
    expect_at(67,  "to_c67",   mk(1, 1, 0, 0, 0, 0));
    expect_at(68,  "to_c68",   mk(0, 1, 0, 0, 1, 0));
    expect_at(71,  "to_c71",   mk(0, 1, 0, 0, 1, 0));
    expect_at(72,  "to_c72",   mk(1, 1, 0, 0, 1, 0));
    expect_at(135, "to_c135",  mk(1, 1, 0, 0, 1, 0));
    expect_at(136, "to_fault", mk(0, 1, 0, 1, 2, 0));
    expect_at(200, "to_stick", mk(0, 1, 0, 1, 2, 0));
    run_to(140);
    bus.PLL_LOCK = 1'b1;
    run_to(201);

    // Qualification finishing exactly on the timeout cycle enters RUN.
    do_reset("edge_run");
    expect_at(67, "er_c67", WAIT0);
    expect_at(68, "er_run", RUN0);
    run_to(57);
    bus.PLL_LOCK = 1'b1;
    run_to(70);

    // One cycle later the timeout fires first.
    do_reset("edge_to");
    expect_at(67, "et_c67", WAIT0);
    expect_at(68, "et_hold", mk(0, 1, 0, 0, 1, 0));
    run_to(58);
    bus.PLL_LOCK = 1'b1;
    run_to(70);

    // Reset asserted mid-STABLE, then a fresh bring-up with lock already present.
    do_reset("mid");
    run_to(10);
    bus.PLL_LOCK = 1'b1;
    run_to(16);
    rst = 1'b1;
    run_to(17);
    rst = 1'b0;
    cyc = 0;
    expect_at(0,  "mid_c0",  HOLD0);
    expect_at(3,  "mid_c3",  HOLD0);
    expect_at(4,  "mid_c4",  WAIT0);
    expect_at(12, "mid_c12", WAIT0);
    expect_at(13, "mid_run", RUN0);
    run_to(25);

    // Repeated lock loss / relock drives LOSS_COUNT into saturation.
    do_reset("sat");
    expect_at(21, "sat_run", RUN0);
    run_to(10);
    bus.PLL_LOCK = 1'b1;
    run_to(25);
    for (int k = 1; k <= 260; k++) begin
      int st;
      logic [7:0] lc;
      st = cyc;
      lc = (k > 255) ? 8'd255 : 8'(k);
      bus.PLL_LOCK = 1'b0;
      expect_at(st + 4, "sat_hold", mk(0, 1, 0, 0, 0, lc));
      run_to(st + 2);
      bus.PLL_LOCK = 1'b1;
      expect_at(st + 18, "sat_relock", mk(1, 0, 1, 0, 0, lc));
      run_to(st + 20);
    end
    cmp("sat_final", {8'd0, bus.LOSS_COUNT}, 16'd255);

    if (q.size() > 0) cmp("end_leftover", 16'(q.size()), 16'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
